xeng_bl_order_gen_v2: RTL and testbench

Parametrised successor to the X-engine baseline-order generator. It tracks the output stream of the correlator core and labels every valid output word with its antenna pair, tap, linear baseline index, redundancy flag and window count. It sits beside the X-engine output (driven by its sync_out/vld_out), feeding the output packetiser and debug benches. It adds the following over the previous generator:
- programmable latency
- odd and even antenna counts
- a last-word strobe
- a window counter
- sync-error detection
- an optional canonical-order (conjugate) mode

---
 rtl/xeng_bl_order_gen_v2.sv | 177 +++++++++++++++++
 tb/tb_xeng_bl_order_gen_v2.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/xeng_bl_order_gen_v2.sv
// Baseline-order generator for the X-engine output stream: labels each valid word with
// antenna pair, tap, linear index, redundancy, last and window count. Optional macro: XENG_BL_CONJ_EN.
module xeng_bl_order_gen_v2 #(
    parameter int N_ANTS        = 32,
    parameter int LATENCY       = 1,
    parameter int WIN_CNT_WIDTH = 16,
    localparam int N_TAPS   = N_ANTS / 2 + 1,
    localparam int ANT_BITS = (N_ANTS > 2) ? $clog2(N_ANTS) : 1,
    localparam int TAP_BITS = (N_TAPS > 2) ? $clog2(N_TAPS) : 1,
    localparam int BL_BITS  = $clog2(N_ANTS * N_TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync,
    input  logic                     en,
    output logic [ANT_BITS-1:0]      ant_a,
    output logic [ANT_BITS-1:0]      ant_b,
    output logic [TAP_BITS-1:0]      tap,
    output logic [BL_BITS-1:0]       bl_idx,
    output logic                     redundant,
    output logic                     last,
    output logic                     vld_out,
    output logic                     sync_out,
    output logic [WIN_CNT_WIDTH-1:0] win_cnt,
`ifdef XENG_BL_CONJ_EN
    output logic                     conj,
`endif
    output logic                     sync_err
);
    localparam int  SUM_W = ANT_BITS + 1;
    localparam bit  EVEN  = (N_ANTS % 2) == 0;

    typedef struct packed {
        logic [ANT_BITS-1:0] ant_a;
        logic [ANT_BITS-1:0] ant_b;
        logic [TAP_BITS-1:0] tap;
        logic [BL_BITS-1:0]  bl_idx;
        logic                redundant;
`ifdef XENG_BL_CONJ_EN
        logic                conj;
`endif
    } label_t;

    logic [ANT_BITS-1:0]      a_q;
    logic [TAP_BITS-1:0]      k_q;
    logic [BL_BITS-1:0]       idx_q;
    logic                     armed_q;
    logic                     err_q;
    logic [WIN_CNT_WIDTH-1:0] win_q;

    logic [ANT_BITS-1:0] cur_a;
    logic [TAP_BITS-1:0] cur_k;
    logic [BL_BITS-1:0]  cur_idx;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    b_sum;
    logic                wrapped;
    logic                k_wrap;
    logic                is_last;
    logic                go;
    label_t              lbl_c;

    // Stage boundary: counters to combinational labels (a sync forces word 0)
    always_comb begin
        cur_a   = sync ? '0 : a_q;
        cur_k   = sync ? '0 : k_q;
        cur_idx = sync ? '0 : idx_q;
        go      = en & (armed_q | sync);
        k_wrap  = cur_k == TAP_BITS'(N_TAPS - 1);
        is_last = k_wrap && (cur_a == ANT_BITS'(N_ANTS - 1));
        sum     = SUM_W'(cur_a) + SUM_W'(cur_k);
        wrapped = sum >= SUM_W'(N_ANTS);
        b_sum   = wrapped ? (sum - SUM_W'(N_ANTS)) : sum;

        lbl_c           = '0;
        lbl_c.ant_a     = cur_a;
        lbl_c.ant_b     = b_sum[ANT_BITS-1:0];
        lbl_c.tap       = cur_k;
        lbl_c.bl_idx    = cur_idx;
        lbl_c.redundant = EVEN && k_wrap && (cur_a >= ANT_BITS'(N_ANTS / 2));
`ifdef XENG_BL_CONJ_EN
        // Wrapped pairs are emitted in canonical order; the data needs conjugating.
        if (wrapped) begin
            lbl_c.ant_a = b_sum[ANT_BITS-1:0];
            lbl_c.ant_b = cur_a;
            lbl_c.conj  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
            win_q   <= '0;
        end else begin
            if (sync)
                armed_q <= 1'b1;
            if (sync && armed_q && (idx_q != '0))
                err_q <= 1'b1;
            if (go) begin
                if (is_last) begin
                    a_q   <= '0;
                    k_q   <= '0;
                    idx_q <= '0;
                    win_q <= win_q + WIN_CNT_WIDTH'(1);
                end else if (k_wrap) begin
                    a_q   <= cur_a + ANT_BITS'(1);
                    k_q   <= '0;
                    idx_q <= cur_idx + BL_BITS'(1);
                end else begin
                    a_q   <= cur_a;
                    k_q   <= cur_k + TAP_BITS'(1);
                    idx_q <= cur_idx + BL_BITS'(1);
                end
            end else if (sync) begin
                a_q   <= '0;
                k_q   <= '0;
                idx_q <= '0;
            end
        end
    end

    label_t                   lbl_p  [LATENCY];
    logic                     vld_p  [LATENCY];
    logic                     last_p [LATENCY];
    logic                     sync_p [LATENCY];
    logic                     err_p  [LATENCY];
    logic [WIN_CNT_WIDTH-1:0] win_p  [LATENCY];

    // Stage boundary: LATENCY output registers; labels only advance with a valid word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                lbl_p[i]  <= '0;
                vld_p[i]  <= 1'b0;
                last_p[i] <= 1'b0;
                sync_p[i] <= 1'b0;
                err_p[i]  <= 1'b0;
                win_p[i]  <= '0;
            end
        end else begin
            vld_p[0]  <= go;
            last_p[0] <= go & is_last;
            sync_p[0] <= sync;
            err_p[0]  <= err_q;
            win_p[0]  <= win_q;
            if (go)
                lbl_p[0] <= lbl_c;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
                sync_p[i] <= sync_p[i-1];
                err_p[i]  <= err_p[i-1];
                win_p[i]  <= win_p[i-1];
                if (vld_p[i-1])
                    lbl_p[i] <= lbl_p[i-1];
            end
        end
    end

    assign ant_a     = lbl_p[LATENCY-1].ant_a;
    assign ant_b     = lbl_p[LATENCY-1].ant_b;
    assign tap       = lbl_p[LATENCY-1].tap;
    assign bl_idx    = lbl_p[LATENCY-1].bl_idx;
    assign redundant = lbl_p[LATENCY-1].redundant;
`ifdef XENG_BL_CONJ_EN
    assign conj      = lbl_p[LATENCY-1].conj;
`endif
    assign last      = last_p[LATENCY-1];
    assign vld_out   = vld_p[LATENCY-1];
    assign sync_out  = sync_p[LATENCY-1];
    assign win_cnt   = win_p[LATENCY-1];
    assign sync_err  = err_p[LATENCY-1];
endmodule

// File: tb/tb_xeng_bl_order_gen_v2.sv
// Directed bench for xeng_bl_order_gen_v2: four instances (N=4/L=1, N=5/L=1, N=4/L=3, N=4/L=2)
// share one stimulus stream; each test resets and checks the instance it targets.
module tb_xeng_bl_order_gen_v2;
    logic clk, rst, sync, en;
    int   errors = 0;
    int   checks = 0;

    // N=4, LATENCY=1
    logic [1:0] a4, b4, t4; logic [3:0] i4; logic r4, l4, v4, s4, e4; logic [15:0] w4;
    // N=5, LATENCY=1
    logic [2:0] a5, b5; logic [1:0] t5; logic [3:0] i5; logic r5, l5, v5, s5, e5; logic [15:0] w5;
    // N=4, LATENCY=3
    logic [1:0] a3, b3, t3; logic [3:0] i3; logic r3, l3, v3, s3, e3; logic [15:0] w3;
    // N=4, LATENCY=2
    logic [1:0] a2, b2, t2; logic [3:0] i2; logic r2, l2, v2, s2, e2; logic [15:0] w2;
`ifdef XENG_BL_CONJ_EN
    logic c4, c5, c3, c2;
`endif

    xeng_bl_order_gen_v2 #(.N_ANTS(4), .LATENCY(1)) u4 (
        .clk(clk), .rst(rst), .sync(sync), .en(en), .ant_a(a4), .ant_b(b4), .tap(t4),
        .bl_idx(i4), .redundant(r4), .last(l4), .vld_out(v4), .sync_out(s4), .win_cnt(w4),
`ifdef XENG_BL_CONJ_EN
        .conj(c4),
`endif
        .sync_err(e4));
    xeng_bl_order_gen_v2 #(.N_ANTS(5), .LATENCY(1)) u5 (
        .clk(clk), .rst(rst), .sync(sync), .en(en), .ant_a(a5), .ant_b(b5), .tap(t5),
        .bl_idx(i5), .redundant(r5), .last(l5), .vld_out(v5), .sync_out(s5), .win_cnt(w5),
`ifdef XENG_BL_CONJ_EN
        .conj(c5),
`endif
        .sync_err(e5));
    xeng_bl_order_gen_v2 #(.N_ANTS(4), .LATENCY(3)) u43 (
        .clk(clk), .rst(rst), .sync(sync), .en(en), .ant_a(a3), .ant_b(b3), .tap(t3),
        .bl_idx(i3), .redundant(r3), .last(l3), .vld_out(v3), .sync_out(s3), .win_cnt(w3),
`ifdef XENG_BL_CONJ_EN
        .conj(c3),
`endif
        .sync_err(e3));
    xeng_bl_order_gen_v2 #(.N_ANTS(4), .LATENCY(2)) u42 (
        .clk(clk), .rst(rst), .sync(sync), .en(en), .ant_a(a2), .ant_b(b2), .tap(t2),
        .bl_idx(i2), .redundant(r2), .last(l2), .vld_out(v2), .sync_out(s2), .win_cnt(w2),
`ifdef XENG_BL_CONJ_EN
        .conj(c2),
`endif
        .sync_err(e2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int a, b;        // raw order
        int ca, cb, cj;  // canonical order
        int red, last;
    } vec_t;
    vec_t tv [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one clock edge, then settle before sampling outputs.
    task automatic step(input logic r, input logic s, input logic e);
        rst = r; sync = s; en = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vexp [8];
        rst = 1'b1; sync = 1'b0; en = 1'b0;

        tv[0]  = '{0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 1, 0, 0, 0};
        tv[2]  = '{0, 2, 0, 2, 0, 0, 0};
        tv[3]  = '{1, 1, 1, 1, 0, 0, 0};
        tv[4]  = '{1, 2, 1, 2, 0, 0, 0};
        tv[5]  = '{1, 3, 1, 3, 0, 0, 0};
        tv[6]  = '{2, 2, 2, 2, 0, 0, 0};
        tv[7]  = '{2, 3, 2, 3, 0, 0, 0};
        tv[8]  = '{2, 0, 0, 2, 1, 1, 0};
        tv[9]  = '{3, 3, 3, 3, 0, 0, 0};
        tv[10] = '{3, 0, 0, 3, 1, 0, 0};
        tv[11] = '{3, 1, 1, 3, 1, 1, 1};

        // Test 1: reset state, then one full N=4 window
        step(1, 0, 0);
        chk("rst_vld", v4, 0);     chk("rst_ant_a", a4, 0);  chk("rst_ant_b", b4, 0);
        chk("rst_bl", i4, 0);      chk("rst_last", l4, 0);   chk("rst_win", w4, 0);
        chk("rst_err", e4, 0);     chk("rst_sync", s4, 0);
        for (int j = 0; j < 12; j++) begin
            step(0, j == 0, 1);
            chk("t1_vld", v4, 1);
            chk("t1_sync_out", s4, (j == 0) ? 1 : 0);
`ifdef XENG_BL_CONJ_EN
            chk("t6_ant_a", a4, tv[j].ca);
            chk("t6_ant_b", b4, tv[j].cb);
            chk("t6_conj", c4, tv[j].cj);
`else
            chk("t1_ant_a", a4, tv[j].a);
            chk("t1_ant_b", b4, tv[j].b);
`endif
            chk("t1_tap", t4, j % 3);
            chk("t1_bl", i4, j);
            chk("t1_red", r4, tv[j].red);
            chk("t1_last", l4, tv[j].last);
            chk("t1_win", w4, 0);
        end
        step(0, 0, 0);
        chk("t1_vld_idle", v4, 0);
        chk("t1_last_idle", l4, 0);
        chk("t1_win_after", w4, 1);

        // Test 2: N=5, two back-to-back windows with sync right after last
        step(1, 0, 0);
        for (int j = 0; j < 30; j++) begin
            step(0, (j == 0) || (j == 15), 1);
            chk("t2_vld", v5, 1);
            chk("t2_ant_a", a5, (j % 15) / 3);
            chk("t2_ant_b", b5, ((j % 15) / 3 + j % 3) % 5);
            chk("t2_tap", t5, j % 3);
            chk("t2_bl", i5, j % 15);
            chk("t2_red", r5, 0);
            chk("t2_last", l5, ((j % 15) == 14) ? 1 : 0);
            chk("t2_win", w5, j / 15);
        end
        step(0, 0, 0);
        chk("t2_win_end", w5, 2);
        chk("t2_err", e5, 0);

        // Test 3: LATENCY=3 with gapped en
        step(1, 0, 0);
        vexp = '{0, 0, 1, 0, 1, 1, 0, 0};
        for (int s = 0; s < 8; s++) begin
            step(0, s == 0, (s == 0) || (s == 2) || (s == 3));
            chk("t3_vld", v3, vexp[s]);
            if (s == 2) chk("t3_bl0", i3, 0);
            if (s == 4) chk("t3_bl1", i3, 1);
            if (s == 5) chk("t3_bl2", i3, 2);
        end

        // Test 4: disarmed en, then sync mid-window
        step(1, 0, 0);
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 1);
            chk("t4_disarmed_vld", v4, 0);
        end
        for (int j = 0; j < 5; j++) begin
            step(0, j == 0, 1);
            chk("t4_pre_bl", i4, j);
        end
        step(0, 1, 1);
        chk("t4_restart_vld", v4, 1);
        chk("t4_restart_a", a4, 0);
        chk("t4_restart_b", b4, 0);
        chk("t4_restart_bl", i4, 0);
        for (int j = 1; j < 12; j++) begin
            step(0, 0, 1);
            chk("t4_bl", i4, j);
            chk("t4_err", e4, 1);
            chk("t4_win_unchanged", w4, 0);
        end
        chk("t4_last", l4, 1);
        step(0, 0, 0);
        chk("t4_win_after", w4, 1);
        step(1, 0, 0);
        chk("t4_err_cleared", e4, 0);
        chk("t4_win_cleared", w4, 0);

        // Test 5: rst mid-window at LATENCY=2
        for (int j = 0; j < 5; j++) begin
            step(0, j == 0, 1);
            if (j > 0) chk("t5_bl", i2, j - 1);
        end
        step(1, 0, 1);
        chk("t5_rst_vld", v2, 0);
        chk("t5_rst_bl", i2, 0);
        chk("t5_rst_a", a2, 0);
        chk("t5_rst_b", b2, 0);
        chk("t5_rst_tap", t2, 0);
        step(0, 0, 1);
        chk("t5_flushed_vld", v2, 0);
        step(0, 0, 1);
        chk("t5_disarmed_vld", v2, 0);
        step(0, 1, 1);
        step(0, 0, 0);
        chk("t5_restart_vld", v2, 1);
        chk("t5_restart_bl", i2, 0);
        chk("t5_restart_sync", s2, 1);
        chk("t5_err", e2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
